// File: rtl/pixel_write_sink.sv
// Pixel-write sink: buffers game-FSM pixel writes in a FIFO and drains them into the
// framebuffer write port on granted cycles; also runs a full-screen clear on request.
module pixel_write_sink #(
  parameter int         DEPTH        = 16,
  parameter int         SCREEN_W     = 160,
  parameter int         SCREEN_H     = 120,
  parameter logic [5:0] CLEAR_COLOUR = 6'd0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  X,
  input  logic [6:0]  Y,
  input  logic [5:0]  colour,
  input  logic        writeEn,
  input  logic        clear_req,
  input  logic        fb_grant,
  output logic [14:0] fb_addr,
  output logic [5:0]  fb_data,
  output logic        fb_wren,
  output logic        busy,
  output logic        full,
  output logic        empty,
  output logic        overflow,
  output logic        range_err
);

  localparam int AW   = $clog2(DEPTH);
  localparam int NPIX = SCREEN_W * SCREEN_H;

  typedef struct packed {
    logic [14:0] addr;
    logic [5:0]  colour;
  } pix_t;

  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

  pix_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nxt;
  state_t        state, state_nxt;
  logic [14:0]   cnt;
  logic [14:0]   addr_in;
  logic          in_range, at_full, push, pop, clr_step, clr_last;

  assign in_range  = (int'(X) < SCREEN_W) && (int'(Y) < SCREEN_H);
  assign addr_in   = 15'(Y) * 15'(SCREEN_W) + 15'(X);
  assign at_full   = (count == (AW+1)'(DEPTH));
  assign pop       = (state == DRAIN) && fb_grant && (count != '0);
  // a full FIFO still accepts a push when an entry leaves on the same edge
  assign push      = writeEn && in_range && (!at_full || pop);
  assign count_nxt = count + (AW+1)'(push) - (AW+1)'(pop);
  assign clr_step  = (state == CLEAR) && fb_grant;
  assign clr_last  = clr_step && (cnt == 15'(NPIX - 1));
  assign busy      = (state == CLEAR);

  // IDLE looks at the incoming push so a fresh pixel drains on the very next edge
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (clear_req)                    state_nxt = CLEAR;
        else if (count != '0 || push)     state_nxt = DRAIN;
      end
      DRAIN: begin
        if (clear_req)                    state_nxt = CLEAR;
        else if (count_nxt == '0)         state_nxt = IDLE;
      end
      CLEAR: begin
        if (clr_last) state_nxt = (count_nxt != '0) ? DRAIN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      overflow  <= 1'b0;
      range_err <= 1'b0;
      fb_addr   <= '0;
      fb_data   <= '0;
      fb_wren   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state != CLEAR && state_nxt == CLEAR) cnt <= '0;
      else if (clr_step)                        cnt <= cnt + 15'd1;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count     <= count_nxt;
      full      <= (count_nxt == (AW+1)'(DEPTH));
      empty     <= (count_nxt == '0);
      overflow  <= overflow  | (writeEn && in_range && at_full && !pop);
      range_err <= range_err | (writeEn && !in_range);
      if (pop) begin
        fb_addr <= mem[rd_ptr].addr;
        fb_data <= mem[rd_ptr].colour;
        fb_wren <= 1'b1;
      end else if (clr_step) begin
        fb_addr <= cnt;
        fb_data <= CLEAR_COLOUR;
        fb_wren <= 1'b1;
      end else begin
        fb_wren <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{addr: addr_in, colour: colour};
  end

endmodule

// File: tb/tb_pixel_write_sink.sv
// Bench for pixel_write_sink: directed scenarios plus random traffic, every cycle
// checked against a queue-based model of pixel writes and the screen clear.
module tb_pixel_write_sink;

  localparam int DEPTH = 16;
  localparam int SW    = 160;
  localparam int SH    = 120;

  logic        clk, reset_n;
  logic [7:0]  X;
  logic [6:0]  Y;
  logic [5:0]  colour;
  logic        writeEn, clear_req, fb_grant;
  logic [14:0] fb_addr;
  logic [5:0]  fb_data;
  logic        fb_wren, busy, full, empty, overflow, range_err;

  pixel_write_sink dut (
    .clk(clk), .reset_n(reset_n), .X(X), .Y(Y), .colour(colour),
    .writeEn(writeEn), .clear_req(clear_req), .fb_grant(fb_grant),
    .fb_addr(fb_addr), .fb_data(fb_data), .fb_wren(fb_wren), .busy(busy),
    .full(full), .empty(empty), .overflow(overflow), .range_err(range_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // model: pending pixel queue, clear progress, last framebuffer write
  typedef struct packed { logic [14:0] a; logic [5:0] c; } ent_t;
  ent_t        q[$];
  bit          m_clr;
  int          m_cptr;
  bit          m_wren, m_ovf, m_rerr;
  logic [14:0] m_addr;
  logic [5:0]  m_data;

  task automatic model_reset();
    q.delete();
    m_clr = 0; m_cptr = 0; m_wren = 0; m_ovf = 0; m_rerr = 0;
    m_addr = '0; m_data = '0;
  endtask

  task automatic model_step();
    bit   was;
    ent_t e;
    was    = m_clr;
    m_wren = 0;
    if (!was && q.size() > 0 && fb_grant) begin
      e = q.pop_front();
      m_wren = 1; m_addr = e.a; m_data = e.c;
    end
    if (was && fb_grant) begin
      m_wren = 1; m_addr = 15'(m_cptr); m_data = 6'd0;
      m_cptr++;
      if (m_cptr == SW*SH) m_clr = 0;
    end
    if (clear_req && !was) begin m_clr = 1; m_cptr = 0; end
    if (writeEn) begin
      if (int'(X) >= SW || int'(Y) >= SH) m_rerr = 1;
      else if (q.size() < DEPTH) q.push_back('{a: 15'(int'(Y)*SW + int'(X)), c: colour});
      else m_ovf = 1;
    end
  endtask

  task automatic chk_all();
    chk("wren",  fb_wren,   m_wren);
    chk("addr",  fb_addr,   m_addr);
    chk("data",  fb_data,   m_data);
    chk("busy",  busy,      m_clr);
    chk("full",  full,      q.size() == DEPTH);
    chk("empty", empty,     q.size() == 0);
    chk("ovf",   overflow,  m_ovf);
    chk("rerr",  range_err, m_rerr);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_wren"},  fb_wren,   0);
    chk({tag, "_addr"},  fb_addr,   0);
    chk({tag, "_data"},  fb_data,   0);
    chk({tag, "_busy"},  busy,      0);
    chk({tag, "_full"},  full,      0);
    chk({tag, "_empty"}, empty,     1);
    chk({tag, "_ovf"},   overflow,  0);
    chk({tag, "_rerr"},  range_err, 0);
  endtask

  // one clock: drive inputs, advance model, sample 1 time unit after the edge
  task automatic cyc(input logic we, input logic [7:0] x, input logic [6:0] y,
                     input logic [5:0] c, input logic cr, input logic g);
    writeEn = we; X = x; Y = y; colour = c; clear_req = cr; fb_grant = g;
    model_step();
    @(posedge clk);
    #1;
    chk_all();
  endtask

  task automatic idle(input int n, input logic g);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, g);
  endtask

  initial begin
    int n;
    reset_n = 1; writeEn = 0; X = 0; Y = 0; colour = 0; clear_req = 0; fb_grant = 0;
    model_reset();
    #1 reset_n = 0;
    #2 chk_reset("rst0");
    @(posedge clk); #1;
    reset_n = 1;

    // single pixel, one-cycle latency
    cyc(1, 8'd3, 7'd2, 6'h3F, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("t1_wren", fb_wren, 1);
    chk("t1_addr", fb_addr, 323);
    chk("t1_data", fb_data, 6'h3F);
    chk("t1_empty", empty, 1);
    idle(2, 1);

    // full FIFO with push and pop together
    for (int i = 0; i < DEPTH; i++) cyc(1, 8'(i + 20), 7'd20, 6'(i), 0, 0);
    chk("t5_full0", full, 1);
    cyc(1, 8'd50, 7'd20, 6'h2A, 0, 1);
    chk("t5_full1", full, 1);
    chk("t5_ovf", overflow, 0);
    idle(DEPTH + 2, 1);

    // overflow on 17th push, then ordered drain
    for (int i = 0; i < DEPTH + 1; i++) cyc(1, 8'(i), 7'd10, 6'(i + 1), 0, 0);
    chk("t2_ovf", overflow, 1);
    idle(DEPTH + 2, 1);
    chk("t2_wren_off", fb_wren, 0);

    // out-of-range writes
    cyc(1, 8'd160, 7'd0, 6'h11, 0, 1);
    cyc(1, 8'd0, 7'd120, 6'h22, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("t3_rerr", range_err, 1);
    chk("t3_empty", empty, 1);

    // full-screen clear with a pixel pushed mid-clear
    cyc(0, 0, 0, 0, 1, 1);
    n = 0;
    while (busy && n < 20000) begin
      n++;
      if (n == 5000) cyc(1, 8'd7, 7'd9, 6'h15, 0, 1);
      else           cyc(0, 0, 0, 0, 0, 1);
    end
    chk("t4_busy_cycles", n, SW*SH);
    idle(3, 1);

    // random traffic, one clear issued partway through
    for (int i = 0; i < 30000; i++)
      cyc(($urandom % 3) != 0, 8'($urandom_range(0, 170)), 7'($urandom_range(0, 125)),
          6'($urandom), i == 1000 || i == 1500, ($urandom % 4) != 0);
    idle(30, 1);

    // asynchronous reset mid-clear
    cyc(1, 8'd1, 7'd1, 6'h01, 1, 1);
    idle(100, 1);
    #2 reset_n = 0;
    #1 chk_reset("t6_rst");
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    chk_reset("t6_hold");
    reset_n = 1;
    idle(20, 1);
    chk("t6_busy", busy, 0);
    chk("t6_wren", fb_wren, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
